// File: rtl/cprv_fetch_queue.sv
// Instruction-fetch stage: owns the PC, keeps pipelined imem requests in flight,
// queues returned instructions in order and presents the head to ID.
module cprv_fetch_queue #(
   parameter int unsigned           INSTR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH   = 64,
   parameter int unsigned           ADDR_WIDTH   = 64,
   parameter int unsigned           FIFO_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_i,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
   output logic                   valid_imem_o,
   input  logic                   ready_imem_i,
   output logic [ADDR_WIDTH-1:0]  instr_addr_imem_o,
   input  logic                   valid_if_i,
   output logic                   ready_if_o,
   input  logic [DATA_WIDTH-1:0]  instr_data_imem_i,
   output logic                   valid_id_o,
   input  logic                   ready_id_i,
   output logic [INSTR_WIDTH-1:0] instr_data_id_o,
   output logic [ADDR_WIDTH-1:0]  instr_pc_id_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       outst_q, outst_d;
   logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [INSTR_WIDTH-1:0] data_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_q   [FIFO_DEPTH];

   logic                   credit;
   logic                   req_fire;
   logic                   resp_drop;
   logic                   push;
   logic                   pop;
   logic [INSTR_WIDTH-1:0] resp_instr;

   // Queue slots plus in-flight requests never exceed the depth, so a response always has room.
   assign credit            = (SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(FIFO_DEPTH);
   assign valid_imem_o      = rst_n & ~redirect_i & credit;
   assign ready_if_o        = rst_n;
   assign instr_addr_imem_o = fetch_pc_q;

   assign req_fire   = valid_imem_o & ready_imem_i;
   assign resp_drop  = valid_if_i & (drop_cnt_q != '0);
   assign push       = valid_if_i & ~resp_drop & ~redirect_i;
   assign pop        = valid_id_o & ready_id_i & ~redirect_i;
   assign resp_instr = resp_pc_q[2] ? instr_data_imem_i[DATA_WIDTH-1 -: INSTR_WIDTH]
                                    : instr_data_imem_i[INSTR_WIDTH-1:0];

   assign valid_id_o      = (count_q != '0);
   assign instr_data_id_o = data_q[head_q];
   assign instr_pc_id_o   = pc_q[head_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(valid_if_i);
      if (redirect_i) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = redirect_pc_i;
         resp_pc_d  = redirect_pc_i;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         drop_cnt_d = outst_d;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end
         if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
            tail_d    = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_VECTOR;
         resp_pc_q  <= RESET_VECTOR;
         count_q    <= '0;
         outst_q    <= '0;
         drop_cnt_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         drop_cnt_q <= drop_cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (!rst_n) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end else if (push && (tail_q == PTR_W'(i))) begin
            data_q[i] <= resp_instr;
            pc_q[i]   <= resp_pc_q;
         end
      end
   end

endmodule
